// File: rtl/scrambler_x58_param.sv
// scrambler_x58_param: self-synchronous 1 + x^39 + x^58 scrambler (MODE=0) / descrambler (MODE=1).
// Define SCRAMBLER_SEED_LOAD_EN to add a run-time seed load port pair.
module scrambler_x58_param #(
    parameter int          DATA_WIDTH = 64,
    parameter int          MODE       = 0,
    parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                  i_txc,
    input  logic                  i_reset_n,
    input  logic                  i_init_done,
    input  logic                  i_tx_pause,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_txd,
`ifdef SCRAMBLER_SEED_LOAD_EN
    input  logic                  i_seed_load,
    input  logic [57:0]           i_seed,
`endif
    output logic [DATA_WIDTH-1:0] o_txd,
    output logic                  o_valid
);
    generate
        if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || MODE < 0 || MODE > 1) begin : g_bad_param
            $error("scrambler_x58_param: DATA_WIDTH must be 32 or 64 and MODE 0 or 1");
        end
    endgenerate
    logic [57:0]           s_q, s_d;
    logic [DATA_WIDTH-1:0] txd_q, y_d;
    logic                  valid_q, adv;
    assign adv = i_init_done & i_valid & ~i_tx_pause;
    // Bit 0 goes first, so each later bit sees the state already shifted by the earlier ones.
    always_comb begin
        s_d = s_q;
        y_d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            y_d[i] = i_txd[i] ^ s_d[38] ^ s_d[57];
            s_d    = {s_d[56:0], (MODE == 0) ? y_d[i] : i_txd[i]};
        end
    end
    always_ff @(posedge i_txc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s_q     <= SEED;
            txd_q   <= '0;
            valid_q <= 1'b0;
        end
`ifdef SCRAMBLER_SEED_LOAD_EN
        else if (i_seed_load) begin
            s_q     <= i_seed;
            valid_q <= 1'b0;
        end
`endif
        else begin
            valid_q <= adv;
            if (adv) begin
                s_q   <= s_d;
                txd_q <= y_d;
            end
        end
    end
    assign o_txd   = txd_q;
    assign o_valid = valid_q;
endmodule

// File: tb/tb_scrambler_x58_param.sv
// tb_scrambler_x58_param: directed vectors plus loopback, self-sync, pause, width and reset sequences.
module tb_scrambler_x58_param;
    localparam logic [57:0] ONES = 58'h3FF_FFFF_FFFF_FFFF;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_init, a_valid, a_pause, z_valid;
    logic [63:0] a_txd;
    logic [31:0] t32;
    logic [63:0] a_y, b_y, c_y, z_y;
    logic [31:0] h_y;
    logic        a_v, b_v, c_v, z_v, h_v;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scrambler_x58_param #(.DATA_WIDTH(64), .MODE(0), .SEED(ONES)) u_a (
        .i_txc(clk), .i_reset_n(rst_n), .i_init_done(a_init), .i_tx_pause(a_pause),
        .i_valid(a_valid), .i_txd(a_txd),
`ifdef SCRAMBLER_SEED_LOAD_EN
        .i_seed_load(1'b0), .i_seed(58'd0),
`endif
        .o_txd(a_y), .o_valid(a_v));
    scrambler_x58_param #(.DATA_WIDTH(64), .MODE(1), .SEED(ONES)) u_b (
        .i_txc(clk), .i_reset_n(rst_n), .i_init_done(1'b1), .i_tx_pause(1'b0),
        .i_valid(a_v), .i_txd(a_y),
`ifdef SCRAMBLER_SEED_LOAD_EN
        .i_seed_load(1'b0), .i_seed(58'd0),
`endif
        .o_txd(b_y), .o_valid(b_v));
    scrambler_x58_param #(.DATA_WIDTH(64), .MODE(1), .SEED(58'd0)) u_c (
        .i_txc(clk), .i_reset_n(rst_n), .i_init_done(1'b1), .i_tx_pause(1'b0),
        .i_valid(a_v), .i_txd(a_y),
`ifdef SCRAMBLER_SEED_LOAD_EN
        .i_seed_load(1'b0), .i_seed(58'd0),
`endif
        .o_txd(c_y), .o_valid(c_v));
    scrambler_x58_param #(.DATA_WIDTH(64), .MODE(0), .SEED(58'd0)) u_z (
        .i_txc(clk), .i_reset_n(rst_n), .i_init_done(1'b1), .i_tx_pause(1'b0),
        .i_valid(z_valid), .i_txd(64'd0),
`ifdef SCRAMBLER_SEED_LOAD_EN
        .i_seed_load(1'b0), .i_seed(58'd0),
`endif
        .o_txd(z_y), .o_valid(z_v));
    scrambler_x58_param #(.DATA_WIDTH(32), .MODE(0), .SEED(ONES)) u_h (
        .i_txc(clk), .i_reset_n(rst_n), .i_init_done(a_init), .i_tx_pause(a_pause),
        .i_valid(a_valid), .i_txd(t32),
`ifdef SCRAMBLER_SEED_LOAD_EN
        .i_seed_load(1'b0), .i_seed(58'd0),
`endif
        .o_txd(h_y), .o_valid(h_v));

    typedef struct {
        logic        init;
        logic        valid;
        logic        pause;
        logic [63:0] data;
        logic        exp_valid;
        logic [63:0] exp_data;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit-serial reference of the polynomial, straight from its definition.
    task automatic mdl(input logic [57:0] s, input logic [63:0] d, input int w, input bit m,
                       output logic [63:0] y, output logic [57:0] ns);
        y = '0;
        for (int i = 0; i < w; i++) begin
            y[i] = d[i] ^ s[38] ^ s[57];
            s = {s[56:0], m ? d[i] : y[i]};
        end
        ns = s;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic init, input logic valid, input logic pause, input logic [63:0] d);
        a_init = init;
        a_valid = valid;
        a_pause = pause;
        a_txd = d;
    endtask

    initial begin
        logic [57:0] ms;
        logic [63:0] y, first, w[4], ey[4], exp;
        logic [31:0] first32;
        logic [63:0] q[$];
        int n_lb;
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 64'd0);
        t32 = '0;
        z_valid = 1'b0;
        #2;
        chk("reset_valid", {63'd0, a_v}, 64'd0);
        chk("reset_txd", a_y, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 64'h0,                   1'b0, 64'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 64'h0,                   1'b0, 64'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 64'h1111_2222_3333_4444, 1'b0, 64'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 64'h5555_6666_7777_8888, 1'b0, 64'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 64'h5555_6666_7777_8888, 1'b0, 64'h0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 64'h9999_9999_9999_9999, 1'b0, 64'h0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 64'h0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0001, 1'b0, 64'h0};
        ms = ONES;
        exp = '0;
        for (int k = 0; k < 11; k++) begin
            if (tbl[k].init && tbl[k].valid && !tbl[k].pause) begin
                mdl(ms, tbl[k].data, 64, 1'b0, y, ms);
                exp = y;
                tbl[k].exp_valid = 1'b1;
            end
            tbl[k].exp_data = exp;
        end
        // All-ones seed with zero data: only bits 39..57 see a fed-back zero against a seed one.
        tbl[1].exp_data = 64'h03FF_FF80_0000_0000;
        for (int k = 0; k < 11; k++) begin
            set_in(tbl[k].init, tbl[k].valid, tbl[k].pause, tbl[k].data);
            step();
            chk($sformatf("tbl%0d_valid", k), {63'd0, a_v}, {63'd0, tbl[k].exp_valid});
            chk($sformatf("tbl%0d_txd", k), a_y, tbl[k].exp_data);
        end

        // Pause holding W2 for three cycles against a pause-free model stream.
        set_in(1'b0, 1'b0, 1'b0, 64'd0);
        do_reset();
        w[0] = 64'hFEDC_BA98_7654_3210;
        w[1] = 64'h0F0F_0F0F_F0F0_F0F0;
        w[2] = 64'h1357_9BDF_2468_ACE0;
        w[3] = 64'hC3C3_3C3C_C3C3_3C3C;
        ms = ONES;
        for (int k = 0; k < 4; k++) mdl(ms, w[k], 64, 1'b0, ey[k], ms);
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, 1'b1, 1'b0, w[k]);
            step();
            chk($sformatf("pause_pre%0d", k), a_y, ey[k]);
        end
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b1, 1'b1, w[2]);
            step();
            chk($sformatf("pause_valid%0d", k), {63'd0, a_v}, 64'd0);
            chk($sformatf("pause_hold%0d", k), a_y, ey[1]);
        end
        for (int k = 2; k < 4; k++) begin
            set_in(1'b1, 1'b1, 1'b0, w[k]);
            step();
            chk($sformatf("pause_post%0d_valid", k), {63'd0, a_v}, 64'd1);
            chk($sformatf("pause_post%0d", k), a_y, ey[k]);
        end

        // Width equivalence: 32-bit A then B against 64-bit {B,A}.
        set_in(1'b0, 1'b0, 1'b0, 64'd0);
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
        t32 = 32'h89AB_CDEF;
        step();
        first = a_y;
        first32 = h_y;
        chk("w32_valid0", {63'd0, h_v}, 64'd1);
        mdl(ONES, 64'h0123_4567_89AB_CDEF, 64, 1'b0, y, ms);
        chk("w64_model", first, y);
        set_in(1'b1, 1'b0, 1'b0, 64'd0);
        t32 = 32'h0123_4567;
        a_valid = 1'b1;
        step();
        chk("w32_concat", {h_y, first32}, first);

        // Loopback into two descramblers, one seeded wrong to show self-sync.
        set_in(1'b0, 1'b0, 1'b0, 64'd0);
        do_reset();
        n_lb = 0;
        for (int k = 0; k < 203; k++) begin
            if (k < 200) begin
                y = {$urandom, $urandom};
                set_in(1'b1, 1'b1, 1'b0, y);
                q.push_back(y);
            end else set_in(1'b1, 1'b0, 1'b0, 64'd0);
            step();
            if (b_v) begin
                if (q.size() == 0) chk("lb_queue_empty", 64'd1, 64'd0);
                else begin
                    exp = q.pop_front();
                    chk($sformatf("lb_%0d", n_lb), b_y, exp);
                    if (n_lb > 0) chk($sformatf("sync_%0d", n_lb), c_y, exp);
                end
                n_lb++;
            end
        end
        chk("lb_count", 64'(n_lb), 64'd200);

        // Zero-state lock.
        set_in(1'b0, 1'b0, 1'b0, 64'd0);
        do_reset();
        z_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("zero_valid%0d", k), {63'd0, z_v}, 64'd1);
            chk($sformatf("zero_txd%0d", k), z_y, 64'd0);
        end
        z_valid = 1'b0;

        // Asynchronous reset mid-stream, then a fresh first word.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 1'b1, 1'b0, {$urandom, $urandom});
            step();
        end
        chk("mid_pre_valid", {63'd0, a_v}, 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, a_v}, 64'd0);
        chk("mid_rst_txd", a_y, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, w[0]);
        step();
        chk("mid_fresh_valid", {63'd0, a_v}, 64'd1);
        chk("mid_fresh_txd", a_y, ey[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
